decoder_seq: RTL

Parametrised, registered one-hot select generator: a binary index is decoded to a `2**SEL_W`-bit one-hot word held in output flops. The index is either loaded and held, or stepped as a wrapping up/down scan over a programmable range. It drives chip-select, mux-select and round-robin strobe lines in the ALU datapath where glitch-free, clocked selects are required.

---
 rtl/decoder_pkg.sv | 24 ++
 rtl/decoder_seq_onehot_dec.sv | 26 ++
 rtl/decoder_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types, constants and helpers for the registered one-hot
// select generator (decoder_seq) and its decoder sub-module (onehot_dec).
package decoder_pkg;

    // Widest index supported by the shared onehot() helper.
    localparam int unsigned MAX_SEL_W = 6;
    localparam int unsigned MAX_OUT_W = 1 << MAX_SEL_W;

    // Scan direction encodings for dir_i.
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_e;

    // One-hot encode an index at the widest supported width; callers truncate.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        onehot = MAX_OUT_W'(1) << idx;
    endfunction

endpackage : decoder_pkg

// File: rtl/decoder_seq_onehot_dec.sv
// onehot_dec: combinational SEL_W -> 2**SEL_W one-hot decoder with enable.
// Ports:
//   en_i   - decoder enable; low forces an all-zero output
//   idx_i  - binary index
//   x_o    - one-hot word, bit idx_i set when enabled
module onehot_dec
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 3
) (
    input  logic                  en_i,
    input  logic [SEL_W-1:0]      idx_i,
    output logic [(1<<SEL_W)-1:0] x_o
);

    localparam int unsigned OUT_W = 1 << SEL_W;

    logic [MAX_OUT_W-1:0] full_c;

    // Decode at the package width, then keep only the low OUT_W lines.
    always_comb begin
        full_c = onehot(MAX_SEL_W'(idx_i));
        x_o    = en_i ? full_c[OUT_W-1:0] : '0;
    end

endmodule : onehot_dec

// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot select generator. A binary index is either
// loaded and held, or stepped as a wrapping up/down scan over [0, LAST].
// Ports:
//   clk           - clock, rising edge
//   rst_n         - asynchronous active-low reset
//   en_i          - block enable; low forces IDLE and clears the select
//   load_valid_i  - load request
//   load_ready_o  - load acceptance (combinational copy of en_i)
//   sel_i         - index to load
//   scan_i        - sampled with a load: 1 = SCAN mode, 0 = HOLD mode
//   dir_i         - scan direction: 0 up, 1 down
//   step_i        - advance the scan by one position
//   x_o           - registered one-hot select (zero when inactive)
//   idx_o         - registered current index
//   active_o      - registered, high in HOLD or SCAN
//   wrap_o        - registered one-cycle pulse on a scan wrap
//   err_o         - registered one-cycle pulse on an out-of-range load
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned LAST  = (1 << SEL_W) - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  scan_i,
    input  logic                  dir_i,
    input  logic                  step_i,
    output logic [(1<<SEL_W)-1:0] x_o,
    output logic [SEL_W-1:0]      idx_o,
    output logic                  active_o,
    output logic                  wrap_o,
    output logic                  err_o
);

    localparam int unsigned OUT_W   = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LAST);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   x_q, x_d;
    logic               active_q, active_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;

    assign load_ready_o = en_i;

    // Next-state: enable gate, then load (wins over step), then scan step.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (load_valid_i) begin
            if (sel_i <= LAST_IDX) begin
                idx_d   = sel_i;
                state_d = scan_i ? SCAN : HOLD;
            end else begin
                err_d = 1'b1;
            end
        end else if (state_q == SCAN && step_i) begin
            if (dir_i == DIR_UP) begin
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end else begin
                if (idx_q == '0) begin
                    idx_d  = LAST_IDX;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q - SEL_W'(1);
                end
            end
        end

        active_d = (state_d != IDLE);
    end

    // Decode the next-state index so x_o moves on the same edge as idx_o.
    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .en_i  (active_d),
        .idx_i (idx_d),
        .x_o   (x_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            x_q      <= '0;
            active_q <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            x_q      <= x_d;
            active_q <= active_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    assign x_o      = x_q;
    assign idx_o    = idx_q;
    assign active_o = active_q;
    assign wrap_o   = wrap_q;
    assign err_o    = err_q;

endmodule : decoder_seq
